// File: rtl/music_seq_player.sv
// Song sequencer and square-wave tone generator: plays note/duration entries from a writable RAM.
// Optional articulation gap (silence over the last GAP_CYC cycles of every note) enabled by MUSIC_GAP_EN.
module music_seq_player #(
    parameter int CLK_HZ   = 100000000,
    parameter int BEAT_CYC = 25000000,
    parameter int SONG_LEN = 32,
    parameter int DIV_W    = 19,
    parameter int GAP_CYC  = 2000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        pause,
    input  logic                        loop,
    input  logic                        wr_en,
    input  logic [$clog2(SONG_LEN)-1:0] wr_addr,
    input  logic [7:0]                  wr_data,
    output logic                        speaker,
    output logic                        playing,
    output logic [$clog2(SONG_LEN)-1:0] note_idx,
    output logic                        done
);
    localparam int AW = $clog2(SONG_LEN);
    localparam int BW = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
    localparam logic [4:0] END_CODE = 5'd31;

    // Tone frequency per note code; 0 marks a rest (and the END marker).
    localparam int FREQ_HZ [32] = '{
        0,   131, 147, 165, 175, 196, 220, 247,
        262, 294, 330, 349, 392, 440, 494, 523,
        587, 659, 698, 784, 880, 988, 0,   0,
        0,   0,   0,   0,   0,   0,   0,   0
    };

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

    state_t            state_reg;
    logic [7:0]        song_mem [SONG_LEN];
    logic [DIV_W-1:0]  half_tab [32];

    logic [AW-1:0]     note_idx_reg;
    logic [2:0]        cur_dur_reg;
    logic [DIV_W-1:0]  cur_half_reg;
    logic              cur_rest_reg;
    logic [BW-1:0]     beat_cnt_reg;
    logic [2:0]        beat_num_reg;
    logic [DIV_W-1:0]  tone_cnt_reg;
    logic              phase_reg;
    logic              speaker_reg;
    logic              playing_reg;
    logic              done_reg;

    logic [AW-1:0]     cand_idx;
    logic [7:0]        cand_entry;
    logic [AW-1:0]     lat_idx;
    logic [7:0]        lat_entry;
    logic              lat_done;
    logic              tone_wrap;
    logic              phase_adv;
    logic              beat_last;
    logic              note_last;
    logic              want_latch;
    logic              load_now;
    logic              finish_now;
    logic              run_now;
    logic              gap_adv;
    logic              gap_cur;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_half
            localparam int F = FREQ_HZ[gi];
            assign half_tab[gi] = (F == 0) ? '0 : DIV_W'(CLK_HZ / (2 * ((F == 0) ? 1 : F)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            song_mem[wr_addr] <= wr_data;
        end
    end

    // Resolve which entry gets latched next; an END marker is skipped over in the same cycle.
    always_comb begin
        cand_idx   = (state_reg == PLAY) ? note_idx_reg + AW'(1) : '0;
        cand_entry = song_mem[cand_idx];
        lat_idx    = cand_idx;
        lat_entry  = cand_entry;
        lat_done   = (state_reg == PLAY) && (note_idx_reg == AW'(SONG_LEN - 1)) && !loop;
        if (cand_entry[4:0] == END_CODE) begin
            if (loop && cand_idx != '0) begin
                lat_idx   = '0;
                lat_entry = song_mem[0];
                if (song_mem[0][4:0] == END_CODE) begin
                    lat_done = 1'b1;
                end
            end else begin
                lat_done = 1'b1;
            end
        end
    end

    always_comb begin
        tone_wrap  = !cur_rest_reg && (tone_cnt_reg == cur_half_reg - DIV_W'(1));
        phase_adv  = phase_reg ^ tone_wrap;
        beat_last  = (beat_cnt_reg == BW'(BEAT_CYC - 1));
        note_last  = beat_last && (beat_num_reg == cur_dur_reg);
        want_latch = !stop && (((state_reg == IDLE || state_reg == DONE) && start && !pause)
                               || (state_reg == PLAY && note_last));
        load_now   = want_latch && !lat_done;
        finish_now = want_latch && lat_done;
        run_now    = !stop && (state_reg == PLAY) && !note_last;
    end

`ifdef MUSIC_GAP_EN
    localparam int NC_W = $clog2(8 * BEAT_CYC + GAP_CYC + 2) + 1;

    logic [NC_W-1:0] note_cyc_reg;
    logic [NC_W-1:0] note_len_reg;

    // Gap test on the elapsed count the speaker register will reflect after this edge.
    assign gap_adv = (note_cyc_reg + NC_W'(GAP_CYC + 1)) >= note_len_reg;
    assign gap_cur = (note_cyc_reg + NC_W'(GAP_CYC)) >= note_len_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            note_cyc_reg <= '0;
            note_len_reg <= '0;
        end else if (load_now) begin
            note_cyc_reg <= '0;
            note_len_reg <= NC_W'((32'(lat_entry[7:5]) + 1) * BEAT_CYC);
        end else if (run_now) begin
            note_cyc_reg <= note_cyc_reg + NC_W'(1);
        end
    end
`else
    assign gap_adv = 1'b0;
    assign gap_cur = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            note_idx_reg <= '0;
            cur_dur_reg  <= '0;
            cur_half_reg <= '0;
            cur_rest_reg <= 1'b1;
            beat_cnt_reg <= '0;
            beat_num_reg <= '0;
            tone_cnt_reg <= '0;
            phase_reg    <= 1'b0;
            speaker_reg  <= 1'b0;
            playing_reg  <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= finish_now;

            if (stop) begin
                state_reg   <= IDLE;
                playing_reg <= 1'b0;
                speaker_reg <= 1'b0;
            end else if (finish_now) begin
                state_reg   <= DONE;
                playing_reg <= 1'b0;
                speaker_reg <= 1'b0;
            end else if (load_now) begin
                state_reg   <= pause ? PAUSE : PLAY;
                playing_reg <= 1'b1;
                speaker_reg <= 1'b0;
            end else if (state_reg == PLAY) begin
                state_reg   <= pause ? PAUSE : PLAY;
                speaker_reg <= !pause && phase_adv && !gap_adv;
            end else if (state_reg == PAUSE && !pause) begin
                state_reg   <= PLAY;
                speaker_reg <= phase_reg && !gap_cur;
            end

            if (load_now) begin
                note_idx_reg <= lat_idx;
                cur_dur_reg  <= lat_entry[7:5];
                cur_half_reg <= half_tab[lat_entry[4:0]];
                cur_rest_reg <= (half_tab[lat_entry[4:0]] == '0);
                beat_cnt_reg <= '0;
                beat_num_reg <= '0;
                tone_cnt_reg <= '0;
                phase_reg    <= 1'b0;
            end else if (run_now) begin
                if (beat_last) begin
                    beat_cnt_reg <= '0;
                    beat_num_reg <= beat_num_reg + 3'd1;
                end else begin
                    beat_cnt_reg <= beat_cnt_reg + BW'(1);
                end
                if (!cur_rest_reg) begin
                    tone_cnt_reg <= tone_wrap ? '0 : tone_cnt_reg + DIV_W'(1);
                end
                phase_reg <= phase_adv;
            end
        end
    end

    assign speaker  = speaker_reg;
    assign playing  = playing_reg;
    assign note_idx = note_idx_reg;
    assign done     = done_reg;

endmodule
